// File: rtl/mem_bist_pkg.sv
// Shared types and the expected-data rule for the memory self-test engine.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_WR,
    ST_CLR_RD,
    ST_CLR_DRAIN,
    ST_PAT_WR,
    ST_PAT_RD,
    ST_PAT_DRAIN,
    ST_DONE
  } bist_state_e;

  typedef enum logic [1:0] {
    BM_ADDR,
    BM_FIXED,
    BM_CHECKER,
    BM_INV_ADDR
  } bist_mode_e;

  // Working width of exp_data; callers truncate to their data width (DW <= 32).
  localparam int XW = 32;

  function automatic logic [XW-1:0] exp_data(input logic            clear,
                                             input bist_mode_e      mode,
                                             input logic [XW-1:0]   addr,
                                             input logic [XW-1:0]   pattern);
    logic [XW-1:0] d;
    d = '0;
    if (!clear) begin
      case (mode)
        BM_ADDR:     d = addr;
        BM_FIXED:    d = pattern;
        BM_CHECKER:  d = addr[0] ? ~pattern : pattern;
        BM_INV_ADDR: d = ~addr;
        default:     d = '0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/mem_bist_rdpipe.sv
// Carries valid/address/expected data of each issued read until its data returns.
module mem_bist_rdpipe #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_exp,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_exp
);

  logic [READ_LAT-1:0] valid_q;
  logic [AW-1:0]       addr_q [READ_LAT];
  logic [DW-1:0]       exp_q  [READ_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < READ_LAT; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // Payload needs no reset: it is only looked at when its valid bit is set.
  always_ff @(posedge clk) begin
    addr_q[0] <= in_addr;
    exp_q[0]  <= in_exp;
    for (int i = 1; i < READ_LAT; i++) begin
      addr_q[i] <= addr_q[i-1];
      exp_q[i]  <= exp_q[i-1];
    end
  end

  assign out_valid = valid_q[READ_LAT-1];
  assign out_addr  = addr_q[READ_LAT-1];
  assign out_exp   = exp_q[READ_LAT-1];

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory self-test engine: clear pass then pattern pass over the whole array,
// counting read mismatches and remembering the first failing address.
module mem_bist_ctrl #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int READ_LAT = 1,
  parameter int ERRW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [DW-1:0]   pattern,
  output logic            mem_read,
  output logic            mem_write,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_data_in,
  input  logic [DW-1:0]   mem_data_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [AW-1:0]   first_err_addr
);
  import mem_bist_pkg::*;

  localparam logic [AW-1:0]   ADDR_LAST  = '1;
  localparam logic [2:0]      DRAIN_LAST = 3'(READ_LAT - 1);
  localparam logic [ERRW-1:0] ERR_MAX    = '1;

  bist_state_e   state, next_state;
  logic [AW-1:0] addr_cnt, addr_next;
  logic [2:0]    drain_cnt, drain_next;
  bist_mode_e    mode_q;
  logic [DW-1:0] pattern_q;

  logic          accept, finish, issue_wr, issue_rd, clear_phase;
  logic [DW-1:0] issue_exp, rd_exp;

  logic          chk_valid, mismatch;
  logic [AW-1:0] chk_addr;
  logic [DW-1:0] chk_exp;
  logic [ERRW-1:0] err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= next_state;
      addr_cnt  <= addr_next;
      drain_cnt <= drain_next;
    end
  end

  always_comb begin
    next_state = state;
    addr_next  = addr_cnt;
    drain_next = drain_cnt;
    accept     = 1'b0;
    finish     = 1'b0;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          addr_next  = '0;
          next_state = ST_CLR_WR;
        end
      end
      ST_CLR_WR, ST_PAT_WR: begin
        issue_wr  = 1'b1;
        addr_next = addr_cnt + 1'b1;
        if (addr_cnt == ADDR_LAST)
          next_state = (state == ST_CLR_WR) ? ST_CLR_RD : ST_PAT_RD;
      end
      ST_CLR_RD, ST_PAT_RD: begin
        issue_rd   = 1'b1;
        addr_next  = addr_cnt + 1'b1;
        drain_next = '0;
        if (addr_cnt == ADDR_LAST)
          next_state = (state == ST_CLR_RD) ? ST_CLR_DRAIN : ST_PAT_DRAIN;
      end
      ST_CLR_DRAIN, ST_PAT_DRAIN: begin
        drain_next = drain_cnt + 3'd1;
        if (drain_cnt == DRAIN_LAST)
          next_state = (state == ST_CLR_DRAIN) ? ST_PAT_WR : ST_DONE;
      end
      ST_DONE: begin
        finish     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign clear_phase = (state == ST_CLR_WR) || (state == ST_CLR_RD);
  assign issue_exp   = DW'(exp_data(clear_phase, mode_q, XW'(addr_cnt), XW'(pattern_q)));

  // Strobes are registered, so the memory sees them one edge after the FSM issues them.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rd_exp      <= '0;
    end else begin
      mem_write   <= issue_wr;
      mem_read    <= issue_rd;
      mem_addr    <= addr_cnt;
      mem_data_in <= issue_wr ? issue_exp : '0;
      rd_exp      <= issue_exp;
    end
  end

  mem_bist_rdpipe #(
    .AW      (AW),
    .DW      (DW),
    .READ_LAT(READ_LAT)
  ) u_rdpipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (mem_read),
    .in_addr  (mem_addr),
    .in_exp   (rd_exp),
    .out_valid(chk_valid),
    .out_addr (chk_addr),
    .out_exp  (chk_exp)
  );

  assign mismatch = chk_valid && (mem_data_out != chk_exp);

  // The final compare lands on the same edge that raises done, so pass looks at err_next.
  always_comb begin
    err_next = err_count;
    if (accept)
      err_next = '0;
    else if (mismatch && (err_count != ERR_MAX))
      err_next = err_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mode_q         <= BM_ADDR;
      pattern_q      <= '0;
    end else begin
      err_count <= err_next;
      done      <= finish;
      if (accept) begin
        busy           <= 1'b1;
        pass           <= 1'b0;
        first_err_addr <= '0;
        mode_q         <= bist_mode_e'(mode);
        pattern_q      <= pattern;
      end
      if (finish) begin
        busy <= 1'b0;
        pass <= (err_next == '0);
      end
      if (mismatch && (err_count == '0))
        first_err_addr <= chk_addr;
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Randomized self-checking bench: two engine instances (latency 1 and 3) on behavioural memories.
module tb_mem_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         total = 0;
  int         bad = 0;

  logic       start_a = 1'b0, mem_read_a, mem_write_a, busy_a, done_a, pass_a;
  logic [1:0] mode_a = '0;
  logic [7:0] pattern_a = '0, mem_data_in_a, mem_data_out_a, err_a;
  logic [4:0] mem_addr_a, first_a;

  logic       start_b = 1'b0, mem_read_b, mem_write_b, busy_b, done_b, pass_b;
  logic [1:0] mode_b = '0;
  logic [7:0] pattern_b = '0, mem_data_in_b, mem_data_out_b;
  logic [3:0] err_b;
  logic [4:0] mem_addr_b, first_b;

  logic       st_en = 1'b0;
  logic [4:0] st_a = '0;
  logic [7:0] st_v = '0;

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  logic [7:0] rdq_a = '0;
  logic [7:0] rdq_b [3];
  int         wr_cnt_a = 0, rd_cnt_a = 0, both_cnt_a = 0;

  always #5 clk = ~clk;

  mem_bist_ctrl #(.AW(5), .DW(8), .READ_LAT(1), .ERRW(8)) dut (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .pattern(pattern_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_addr(mem_addr_a),
    .mem_data_in(mem_data_in_a), .mem_data_out(mem_data_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_addr(first_a)
  );

  mem_bist_ctrl #(.AW(5), .DW(8), .READ_LAT(3), .ERRW(4)) dut_l3 (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .pattern(pattern_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
    .mem_data_in(mem_data_in_b), .mem_data_out(mem_data_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_addr(first_b)
  );

  // Memory A: one-cycle read latency, optional stuck-at word on read.
  always @(posedge clk) begin
    if (mem_write_a) mem_a[mem_addr_a] <= mem_data_in_a;
    if (mem_read_a) rdq_a <= (st_en && mem_addr_a == st_a) ? st_v : mem_a[mem_addr_a];
    if (mem_write_a) wr_cnt_a++;
    if (mem_read_a) rd_cnt_a++;
    if (mem_write_a && mem_read_a) both_cnt_a++;
  end
  assign mem_data_out_a = rdq_a;

  // Memory B: three-cycle read latency, every read returns bit 0 flipped.
  always @(posedge clk) begin
    if (mem_write_b) mem_b[mem_addr_b] <= mem_data_in_b;
    rdq_b[0] <= mem_b[mem_addr_b] ^ 8'h01;
    rdq_b[1] <= rdq_b[0];
    rdq_b[2] <= rdq_b[1];
  end
  assign mem_data_out_b = rdq_b[2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] model_word(input int m, input logic [7:0] p, input int a);
    logic [7:0] av;
    av = 8'(a);
    case (m)
      0:       return av;
      1:       return p;
      2:       return (a % 2 == 1) ? ~p : p;
      default: return ~av;
    endcase
  endfunction

  // Whole-run outcome: every address read once after the clear pass and once after the pattern pass.
  function automatic void modelRun(input int m, input logic [7:0] p, input logic sen,
                                   input int sa, input logic [7:0] sv, input logic [7:0] flip,
                                   input int errmax, output int n_err, output int first);
    logic [7:0] want, seen;
    n_err = 0;
    first = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < 32; a++) begin
        want = (ph == 0) ? 8'h00 : model_word(m, p, a);
        seen = (sen && a == sa) ? sv : (want ^ flip);
        if (seen != want) begin
          if (n_err == 0) first = a;
          if (n_err < errmax) n_err++;
        end
      end
    end
  endfunction

  task automatic applyStimulus(input string tag, input logic [1:0] m, input logic [7:0] p,
                               input int restart_at, input int rst_at);
    int cyc, dones, wr0, rd0, both0, e_err, e_first;
    logic e_pass;
    modelRun(int'(m), p, st_en, int'(st_a), st_v, 8'h00, 255, e_err, e_first);
    e_pass = (e_err == 0);
    wr0 = wr_cnt_a; rd0 = rd_cnt_a; both0 = both_cnt_a;
    @(negedge clk);
    mode_a = m; pattern_a = p; start_a = 1'b1;
    cyc = 0; dones = 0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start_a = (cyc == restart_at);
      if (cyc == 1) checkOutput({tag, ".busy_start"}, 32'(busy_a), 1);
      if (rst_at != 0) begin
        rst = (cyc == rst_at);
        if (cyc == rst_at + 1)
          checkOutput({tag, ".after_rst"}, 32'({mem_read_a, mem_write_a, busy_a}), 0);
        if (done_a) dones++;
      end else if (done_a) begin
        break;
      end
    end
    if (rst_at != 0) begin
      checkOutput({tag, ".no_done"}, dones, 0);
      return;
    end
    checkOutput({tag, ".cycles"}, cyc, 4 * 32 + 2 * 1 + 2);
    checkOutput({tag, ".busy_end"}, 32'(busy_a), 0);
    checkOutput({tag, ".err"}, 32'(err_a), e_err);
    checkOutput({tag, ".first"}, 32'(first_a), e_first);
    checkOutput({tag, ".pass"}, 32'(pass_a), 32'(e_pass));
    checkOutput({tag, ".writes"}, wr_cnt_a - wr0, 64);
    checkOutput({tag, ".reads"}, rd_cnt_a - rd0, 64);
    checkOutput({tag, ".rdwr_both"}, both_cnt_a - both0, 0);
    checkOutput({tag, ".mem0"}, 32'(mem_a[0]), 32'(model_word(int'(m), p, 0)));
    checkOutput({tag, ".mem1"}, 32'(mem_a[1]), 32'(model_word(int'(m), p, 1)));
    checkOutput({tag, ".mem31"}, 32'(mem_a[31]), 32'(model_word(int'(m), p, 31)));
    @(posedge clk); #1;
    checkOutput({tag, ".hold"}, 32'({done_a, pass_a, err_a}), 32'({1'b0, e_pass, 8'(e_err)}));
  endtask

  initial begin
    int cyc, e_err, e_first;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_a", 32'({mem_read_a, mem_write_a, busy_a, done_a, pass_a, err_a,
                                first_a, mem_addr_a, mem_data_in_a}), 0);
    checkOutput("reset_b", 32'({mem_read_b, mem_write_b, busy_b, done_b, pass_b, err_b,
                                first_b, mem_addr_b, mem_data_in_b}), 0);
    rst = 1'b0;

    applyStimulus("healthy_m0", 2'd0, 8'h00, 0, 0);
    st_en = 1'b1; st_a = 5'd5; st_v = 8'h04;
    applyStimulus("stuck5_m1", 2'd1, 8'hE9, 0, 0);
    st_en = 1'b0;
    applyStimulus("checker_aa", 2'd2, 8'hAA, 0, 0);
    applyStimulus("restart_ign", 2'd3, 8'h00, 10, 0);
    applyStimulus("rst_mid", 2'd1, 8'h3C, 0, 40);
    applyStimulus("after_rst", 2'd0, 8'h00, 0, 0);

    for (int i = 0; i < 6; i++) begin
      st_en = 1'($urandom_range(0, 1));
      st_a  = 5'($urandom_range(0, 31));
      st_v  = 8'($urandom);
      applyStimulus($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), 8'($urandom), 0, 0);
    end
    st_en = 1'b0;

    mode_b = 2'($urandom_range(0, 3));
    pattern_b = 8'($urandom);
    modelRun(int'(mode_b), pattern_b, 1'b0, 0, 8'h00, 8'h01, 15, e_err, e_first);
    @(negedge clk);
    start_b = 1'b1;
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start_b = 1'b0;
      if (done_b) break;
    end
    checkOutput("lat3.cycles", cyc, 4 * 32 + 2 * 3 + 2);
    checkOutput("lat3.err", 32'(err_b), e_err);
    checkOutput("lat3.first", 32'(first_b), e_first);
    checkOutput("lat3.pass", 32'(pass_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
